uart_tx_fifo: RTL

UART transmitter with a small byte buffer, upstream of the UART receiver on the loopback path. Accepts bytes on a valid/ready handshake and buffers them in a FIFO. Serialises each byte as 8N1, LSB first, onto a single line that drives the receiver's serial input. Bit period is set by the same CLK_PER_BITS parameter the receiver uses.

---
 rtl/uart_tx_fifo.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - FIFO-buffered 8N1 UART transmitter, LSB first
// Optional even-parity bit between data and stop when UART_TX_PARITY_EN is defined.
module uart_tx_fifo #(
    parameter int CLK_PER_BITS = 1086,
    parameter int FIFO_DEPTH   = 4,
    parameter int ADDR_W       = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx_serial,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   fifo_count
);
    localparam int CNT_W = (CLK_PER_BITS > 1) ? $clog2(CLK_PER_BITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_PER_BITS - 1);
    localparam logic [ADDR_W:0]  DEPTH    = (ADDR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        STOP    = 3'd3,
        CLEANUP = 3'd4
`ifdef UART_TX_PARITY_EN
        , PARITY = 3'd5
`endif
    } state_t;

    state_t            state;
    logic [7:0]        mem [FIFO_DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [7:0]        shift_reg;
    logic [CNT_W-1:0]  cnt;
    logic [2:0]        bit_idx;
    logic              push;
    logic              pop;

    assign tx_ready = (fifo_count != DEPTH);
    assign busy     = (state != IDLE);
    assign push     = tx_valid && tx_ready;
    assign pop      = (state == IDLE) && (fifo_count != '0);

    // Storage has no reset; only the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= tx_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            shift_reg  <= '0;
            cnt        <= '0;
            bit_idx    <= '0;
            tx_serial  <= 1'b1;
            done       <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + (ADDR_W + 1)'(1);
                2'b01:   fifo_count <= fifo_count - (ADDR_W + 1)'(1);
                default: fifo_count <= fifo_count;
            endcase

            done <= 1'b0;
            case (state)
                IDLE: begin
                    tx_serial <= 1'b1;
                    cnt       <= '0;
                    if (pop) begin
                        shift_reg <= mem[rd_ptr];
                        tx_serial <= 1'b0;
                        state     <= START;
                    end
                end
                START: begin
                    if (cnt == CNT_LAST) begin
                        cnt       <= '0;
                        bit_idx   <= '0;
                        tx_serial <= shift_reg[0];
                        state     <= DATA;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (cnt == CNT_LAST) begin
                        cnt <= '0;
                        if (bit_idx != 3'd7) begin
                            bit_idx   <= bit_idx + 3'd1;
                            tx_serial <= shift_reg[bit_idx + 3'd1];
                        end else begin
`ifdef UART_TX_PARITY_EN
                            tx_serial <= ^shift_reg;
                            state     <= PARITY;
`else
                            tx_serial <= 1'b1;
                            state     <= STOP;
`endif
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (cnt == CNT_LAST) begin
                        cnt       <= '0;
                        tx_serial <= 1'b1;
                        state     <= STOP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
`endif
                STOP: begin
                    if (cnt == CNT_LAST) begin
                        cnt       <= '0;
                        tx_serial <= 1'b1;
                        done      <= 1'b1;
                        state     <= CLEANUP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                CLEANUP: begin
                    tx_serial <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    tx_serial <= 1'b1;
                    cnt       <= '0;
                    state     <= IDLE;
                end
            endcase
        end
    end
endmodule
